// File: rtl/snake_fb_update_ctrl_pkg.sv
// Shared definitions for the snake frame-buffer redraw controller:
// cell codes, FSM encoding and the default grid depth.
package snake_fb_update_ctrl_pkg;

   localparam logic [1:0] CELL_EMPTY      = 2'b00;
   localparam logic [1:0] CELL_SNAKE_BODY = 2'b01;
   localparam logic [1:0] CELL_SNAKE_HEAD = 2'b10;
   localparam logic [1:0] CELL_FOOD       = 2'b11;

   localparam int GRID_W_DEFAULT = 60;
   localparam int GRID_H_DEFAULT = 40;
   localparam int GRID_DEPTH     = GRID_W_DEFAULT * GRID_H_DEFAULT;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      SNAKE = 3'd2,
      DRAIN = 3'd3,
      HEAD  = 3'd4,
      FOOD  = 3'd5
   } state_t;

endpackage

// File: rtl/snake_fb_update_ctrl_seg_rd_arbiter.sv
// Fixed-priority arbiter for the segment RAM read port: the game core
// always wins, the redraw controller only gets the port when it is free.
module snake_seg_rd_arbiter #(
   parameter int S_ADDR_W = 8
) (
   input  logic                game_rd_req,
   input  logic                ctrl_rd_req,
   input  logic [S_ADDR_W-1:0] ctrl_rd_addr,
   output logic                seg_rd_en,
   output logic [S_ADDR_W-1:0] seg_rd_addr,
   output logic                ctrl_grant
);

   assign ctrl_grant  = ctrl_rd_req & ~game_rd_req;
   assign seg_rd_en   = ctrl_grant;
   assign seg_rd_addr = ctrl_rd_addr;

endmodule

// File: rtl/snake_fb_update_ctrl.sv
// Per-frame redraw sequencer for the 2-bit snake frame buffer: clear pass,
// body walk through the shared segment RAM, then head and food stamps.
module snake_fb_update_ctrl
   import snake_fb_update_ctrl_pkg::*;
#(
   parameter int X_BITS    = 6,
   parameter int Y_BITS    = 6,
   parameter int S_LEN_W   = 8,
   parameter int S_ADDR_W  = 8,
   parameter int GRID_W    = 60,
   parameter int GRID_H    = 40,
   parameter int FB_ADDR_W = 12
) (
   input  logic                 sys_clk,
   input  logic                 sys_reset_n,
   input  logic                 frame_tick,
   input  logic [S_LEN_W-1:0]   snake_length_in,
   input  logic [X_BITS-1:0]    snake_head_x_in,
   input  logic [Y_BITS-1:0]    snake_head_y_in,
   input  logic [X_BITS-1:0]    food_x_in,
   input  logic [Y_BITS-1:0]    food_y_in,
   input  logic                 game_rd_req,
   output logic                 seg_rd_en,
   output logic [S_ADDR_W-1:0]  seg_rd_addr,
   input  logic [X_BITS-1:0]    seg_x_in,
   input  logic [Y_BITS-1:0]    seg_y_in,
   input  logic                 seg_valid_in,
   output logic                 fb_we,
   output logic [FB_ADDR_W-1:0] fb_waddr,
   output logic [1:0]           fb_wdata,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 overrun,
   output state_t               dbg_state
);

   localparam int DEPTH = GRID_W * GRID_H;

   state_t                state, next_state;
   logic [FB_ADDR_W-1:0]  clr_cnt, clr_cnt_nx;
   logic [S_ADDR_W-1:0]   seg_cnt, seg_cnt_nx;
   logic [S_LEN_W-1:0]    len_q;
   logic [X_BITS-1:0]     head_x_q, food_x_q;
   logic [Y_BITS-1:0]     head_y_q, food_y_q;
   logic                  rd_pending;
   logic                  snap;
   logic                  ctrl_rd_req, ctrl_grant;
   logic                  wr_en;
   logic [FB_ADDR_W-1:0]  wr_addr;
   logic [1:0]            wr_data;

   function automatic logic in_grid(input logic [X_BITS-1:0] x, input logic [Y_BITS-1:0] y);
      return (32'(x) < 32'(GRID_W)) && (32'(y) < 32'(GRID_H));
   endfunction

   function automatic logic [FB_ADDR_W-1:0] cell_addr(input logic [X_BITS-1:0] x,
                                                      input logic [Y_BITS-1:0] y);
      logic [31:0] full;
      full = 32'(y) * 32'(GRID_W) + 32'(x);
      return full[FB_ADDR_W-1:0];
   endfunction

   // Segment read port: seg_rd_en is a request issued only while the game core
   // leaves the port idle; data returns exactly one cycle later qualified by
   // seg_valid_in, with no backpressure in either direction.
   assign ctrl_rd_req = sys_reset_n && (state == SNAKE);

   snake_seg_rd_arbiter #(.S_ADDR_W(S_ADDR_W)) u_arb (
      .game_rd_req  (game_rd_req),
      .ctrl_rd_req  (ctrl_rd_req),
      .ctrl_rd_addr (seg_cnt),
      .seg_rd_en    (seg_rd_en),
      .seg_rd_addr  (seg_rd_addr),
      .ctrl_grant   (ctrl_grant)
   );

   assign busy      = (state != IDLE);
   assign overrun   = sys_reset_n && frame_tick && (state != IDLE);
   assign dbg_state = state;

   always_comb begin
      next_state = state;
      clr_cnt_nx = clr_cnt;
      seg_cnt_nx = seg_cnt;
      snap       = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_data    = CELL_EMPTY;

      // Body returns can land in any state; the FSM never overlaps them with its own writes.
      if (rd_pending && seg_valid_in && in_grid(seg_x_in, seg_y_in)) begin
         wr_en   = 1'b1;
         wr_addr = cell_addr(seg_x_in, seg_y_in);
         wr_data = CELL_SNAKE_BODY;
      end

      case (state)
         IDLE: begin
            if (frame_tick) begin
               snap       = 1'b1;
               clr_cnt_nx = '0;
               next_state = CLEAR;
            end
         end
         CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt;
            wr_data = CELL_EMPTY;
            if (clr_cnt == FB_ADDR_W'(DEPTH - 1)) begin
               clr_cnt_nx = '0;
               seg_cnt_nx = S_ADDR_W'(1);
               next_state = (len_q <= S_LEN_W'(1)) ? HEAD : SNAKE;
            end else begin
               clr_cnt_nx = clr_cnt + 1'b1;
            end
         end
         SNAKE: begin
            if (ctrl_grant) begin
               seg_cnt_nx = seg_cnt + 1'b1;
               if ((32'(seg_cnt) + 32'd1) == 32'(len_q)) next_state = DRAIN;
            end
         end
         DRAIN: next_state = HEAD;
         HEAD: begin
            if (in_grid(head_x_q, head_y_q)) begin
               wr_en   = 1'b1;
               wr_addr = cell_addr(head_x_q, head_y_q);
               wr_data = CELL_SNAKE_HEAD;
            end
            next_state = FOOD;
         end
         FOOD: begin
            if (in_grid(food_x_q, food_y_q)) begin
               wr_en   = 1'b1;
               wr_addr = cell_addr(food_x_q, food_y_q);
               wr_data = CELL_FOOD;
            end
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_reset_n) begin
         state      <= CLEAR;
         clr_cnt    <= '0;
         seg_cnt    <= S_ADDR_W'(1);
         rd_pending <= 1'b0;
         fb_we      <= 1'b0;
         fb_waddr   <= '0;
         fb_wdata   <= CELL_EMPTY;
         frame_done <= 1'b0;
         // Off-grid snapshot: the power-up frame is a pure clear pass.
         len_q      <= '0;
         head_x_q   <= '1;
         head_y_q   <= '1;
         food_x_q   <= '1;
         food_y_q   <= '1;
      end else begin
         state      <= next_state;
         clr_cnt    <= clr_cnt_nx;
         seg_cnt    <= seg_cnt_nx;
         rd_pending <= seg_rd_en;
         fb_we      <= wr_en;
         fb_waddr   <= wr_addr;
         fb_wdata   <= wr_data;
         frame_done <= (state == FOOD);
         if (snap) begin
            len_q    <= snake_length_in;
            head_x_q <= snake_head_x_in;
            head_y_q <= snake_head_y_in;
            food_x_q <= food_x_in;
            food_y_q <= food_y_in;
         end
      end
   end

endmodule

// File: tb/tb_snake_fb_update_ctrl.sv
// Directed self-checking bench for snake_fb_update_ctrl.
module tb_snake_fb_update_ctrl;
   import snake_fb_update_ctrl_pkg::*;

   logic        sys_clk = 1'b0;
   logic        sys_reset_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic [7:0]  snake_length_in = '0;
   logic [5:0]  snake_head_x_in = '0, snake_head_y_in = '0;
   logic [5:0]  food_x_in = '0, food_y_in = '0;
   logic        game_rd_req = 1'b0;
   logic        seg_rd_en;
   logic [7:0]  seg_rd_addr;
   logic [5:0]  seg_x_in, seg_y_in;
   logic        seg_valid_in;
   logic        fb_we;
   logic [11:0] fb_waddr;
   logic [1:0]  fb_wdata;
   logic        busy, frame_done, overrun;
   state_t      dbg_state;

   snake_fb_update_ctrl dut (
      .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .frame_tick(frame_tick),
      .snake_length_in(snake_length_in),
      .snake_head_x_in(snake_head_x_in), .snake_head_y_in(snake_head_y_in),
      .food_x_in(food_x_in), .food_y_in(food_y_in),
      .game_rd_req(game_rd_req), .seg_rd_en(seg_rd_en), .seg_rd_addr(seg_rd_addr),
      .seg_x_in(seg_x_in), .seg_y_in(seg_y_in), .seg_valid_in(seg_valid_in),
      .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata),
      .busy(busy), .frame_done(frame_done), .overrun(overrun), .dbg_state(dbg_state)
   );

   // clock / cycle count
   always #5 sys_clk = ~sys_clk;
   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // segment RAM model: one-cycle read latency
   logic [5:0] mem_x [256];
   logic [5:0] mem_y [256];
   always @(posedge sys_clk) begin
      seg_valid_in <= seg_rd_en;
      seg_x_in     <= mem_x[seg_rd_addr];
      seg_y_in     <= mem_y[seg_rd_addr];
   end

   // write monitor
   logic [11:0] got_a [$];
   logic [1:0]  got_d [$];
   int          got_c [$];
   int          fd_cnt = 0, fd_cyc = 0, ov_cnt = 0;
   always @(negedge sys_clk) begin
      if (fb_we === 1'b1) begin
         got_a.push_back(fb_waddr);
         got_d.push_back(fb_wdata);
         got_c.push_back(cyc);
      end
      if (frame_done === 1'b1) begin
         fd_cnt = fd_cnt + 1;
         fd_cyc = cyc;
      end
   end
   always @(posedge sys_clk) if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic flush();
      got_a.delete();
      got_d.delete();
      got_c.delete();
   endtask

   task automatic set_live(input int len, input int hx, input int hy, input int fx, input int fy);
      snake_length_in = 8'(len);
      snake_head_x_in = 6'(hx);
      snake_head_y_in = 6'(hy);
      food_x_in       = 6'(fx);
      food_y_in       = 6'(fy);
   endtask

   // Tick for one cycle, return the tick cycle, then scramble the live inputs.
   task automatic pulse_tick(output int c);
      frame_tick = 1'b1;
      c = cyc;
      step();
      frame_tick = 1'b0;
      set_live(9, 1, 1, 2, 2);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 5000) begin
         step();
         n++;
      end
      chk(tag, 64'(n < 5000), 64'd1);
   endtask

   task automatic wait_snake(input string tag);
      int n = 0;
      while (dbg_state !== SNAKE && n < 5000) begin
         step();
         n++;
      end
      chk(tag, 64'(n < 5000), 64'd1);
   endtask

   task automatic check_clear(input string tag, input int c_first);
      int errs = 0;
      for (int i = 0; i < GRID_DEPTH; i++) begin
         if (got_a.size() == 0) errs++;
         else begin
            logic [11:0] a;
            logic [1:0]  d;
            int          c;
            a = got_a.pop_front();
            d = got_d.pop_front();
            c = got_c.pop_front();
            if (a !== 12'(i) || d !== CELL_EMPTY || c != c_first + i) errs++;
         end
      end
      chk(tag, 64'(errs), 64'd0);
   endtask

   task automatic expect_wr(input string tag, input int ea, input int ed, input int ec);
      logic [63:0] obs;
      if (got_a.size() == 0) obs = '1;
      else obs = {32'(got_c.pop_front()), 16'(got_a.pop_front()), 16'(got_d.pop_front())};
      chk(tag, obs, {32'(ec), 16'(ea), 16'(ed)});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, k, r, fd0, ov0;
      for (int i = 0; i < 256; i++) begin
         mem_x[i] = '0;
         mem_y[i] = '0;
      end

      // reset state
      step();
      step();
      chk("rst_fb_we", fb_we, 0);
      chk("rst_fb_waddr", fb_waddr, 0);
      chk("rst_fb_wdata", fb_wdata, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_seg_rd_en", seg_rd_en, 0);
      chk("rst_busy", busy, 1);
      chk("rst_state", dbg_state, CLEAR);
      flush();

      // power-up clear pass
      sys_reset_n = 1'b1;
      r = cyc;
      wait_idle("pwr_idle");
      check_clear("pwr_clear", r + 1);
      chk("pwr_no_extra", got_a.size(), 0);
      chk("pwr_frame_done", fd_cnt, 1);
      chk("pwr_fb_we_low", fb_we, 0);

      // frame 1: length 3, unstalled
      mem_x[1] = 5; mem_y[1] = 5;
      mem_x[2] = 6; mem_y[2] = 5;
      set_live(3, 7, 5, 10, 20);
      fd0 = fd_cnt;
      pulse_tick(c);
      wait_idle("f1_idle");
      check_clear("f1_clear", c + 2);
      expect_wr("f1_body0", 305, 1, c + 2403);
      expect_wr("f1_body1", 306, 1, c + 2404);
      expect_wr("f1_head", 307, 2, c + 2405);
      expect_wr("f1_food", 1210, 3, c + 2406);
      chk("f1_no_extra", got_a.size(), 0);
      chk("f1_fd_count", fd_cnt - fd0, 1);
      chk("f1_fd_cycle", fd_cyc, c + 2406);

      // frame 2: same frame, game core holds the port for 4 cycles
      set_live(3, 7, 5, 10, 20);
      pulse_tick(c);
      wait_snake("f2_reach_snake");
      chk("f2_snake_cycle", cyc, c + 2401);
      chk("f2_rd_en_pre", seg_rd_en, 1);
      chk("f2_rd_addr_pre", seg_rd_addr, 1);
      game_rd_req = 1'b1;
      #1;
      chk("f2_rd_en_fall", seg_rd_en, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("f2_rd_en_stall", seg_rd_en, 0);
      end
      step();
      game_rd_req = 1'b0;
      #1;
      chk("f2_rd_en_resume", seg_rd_en, 1);
      chk("f2_rd_addr_resume", seg_rd_addr, 1);
      wait_idle("f2_idle");
      check_clear("f2_clear", c + 2);
      expect_wr("f2_body0", 305, 1, c + 2407);
      expect_wr("f2_body1", 306, 1, c + 2408);
      expect_wr("f2_head", 307, 2, c + 2409);
      expect_wr("f2_food", 1210, 3, c + 2410);
      chk("f2_fd_cycle", fd_cyc, c + 2410);

      // frame 3: off-grid body segment and food
      mem_x[1] = 60; mem_y[1] = 3;
      set_live(2, 2, 2, 0, 40);
      fd0 = fd_cnt;
      pulse_tick(c);
      wait_idle("f3_idle");
      check_clear("f3_clear", c + 2);
      expect_wr("f3_head", 122, 2, c + 2404);
      chk("f3_no_extra", got_a.size(), 0);
      chk("f3_fd_count", fd_cnt - fd0, 1);
      chk("f3_fd_cycle", fd_cyc, c + 2405);

      // frame 4: length 1, dropped tick during CLEAR
      set_live(1, 59, 39, 0, 0);
      fd0 = fd_cnt;
      ov0 = ov_cnt;
      pulse_tick(c);
      repeat (100) step();
      frame_tick = 1'b1;
      #1;
      chk("f4_overrun_pulse", overrun, 1);
      step();
      frame_tick = 1'b0;
      #1;
      chk("f4_overrun_low", overrun, 0);
      wait_idle("f4_idle");
      check_clear("f4_clear", c + 2);
      expect_wr("f4_head", 2399, 2, c + 2402);
      expect_wr("f4_food", 0, 3, c + 2403);
      chk("f4_no_extra", got_a.size(), 0);
      chk("f4_fd_count", fd_cnt - fd0, 1);
      chk("f4_ov_count", ov_cnt - ov0, 1);
      repeat (5) step();
      chk("f4_no_restart", busy, 0);

      // frame 5: reset pulse during SNAKE aborts the frame
      for (int i = 1; i < 5; i++) begin
         mem_x[i] = 6'(i);
         mem_y[i] = 6'd1;
      end
      set_live(5, 0, 1, 5, 5);
      pulse_tick(c);
      wait_snake("f5_reach_snake");
      step();
      step();
      sys_reset_n = 1'b0;
      k = cyc;
      #1;
      chk("f5_rd_en_in_reset", seg_rd_en, 0);
      flush();
      fd0 = fd_cnt;
      step();
      chk("f5_fb_we_reset", fb_we, 0);
      sys_reset_n = 1'b1;
      wait_idle("f5_idle");
      check_clear("f5_clear", k + 2);
      chk("f5_no_extra", got_a.size(), 0);
      chk("f5_fd_count", fd_cnt - fd0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/snake_fb_update_ctrl.md
# snake_fb_update_ctrl

Sequences the per-frame redraw of the 2-bit snake frame buffer, and shares the snake-segment memory read port with the game core. Once per frame it clears the buffer, walks the body segments, then stamps the head and the food. The block sits between the game core (segment RAM, head, food, length) and the renderer's frame buffer write port. The game core always has priority on the segment read port; the redraw stalls around it.

## Interface
Parameters:
- X_BITS, 6, grid x width
- Y_BITS, 6, grid y width
- S_LEN_W, 8, snake length width
- S_ADDR_W, 8, segment RAM address width
- GRID_W, 60, grid columns
- GRID_H, 40, grid rows
- FB_ADDR_W, 12, frame buffer address width (must satisfy 2^FB_ADDR_W ≥ GRID_W*GRID_H)

Ports:
- Clock and reset are decided: one clock; reset is synchronous and active-low.
- sys_clk  in  1  sole clock
- sys_reset_n  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame, already synchronized to sys_clk
- snake_length_in  in  S_LEN_W  segment count, head included
- snake_head_x_in / snake_head_y_in  in  X_BITS / Y_BITS  head cell
- food_x_in / food_y_in  in  X_BITS / Y_BITS  food cell
- game_rd_req  in  1  game core uses the segment read port this cycle
- seg_rd_en  out  1  controller read strobe (combinational)
- seg_rd_addr  out  S_ADDR_W  controller read address (combinational)
- seg_x_in / seg_y_in  in  X_BITS / Y_BITS  read data, valid one cycle after seg_rd_en
- seg_valid_in  in  1  read data qualifier, same cycle as seg_x_in / seg_y_in
- fb_we  out  1  frame buffer write enable (registered)
- fb_waddr  out  FB_ADDR_W  write address (registered)
- fb_wdata  out  2  cell code (registered)
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse at the food write
- overrun  out  1  one-cycle pulse when a frame_tick is dropped

## Operation
- States: IDLE, CLEAR, SNAKE, DRAIN, HEAD, FOOD.
- Reset:
  - state=CLEAR, clear counter=0, seg counter=1.
  - fb_we=0, fb_waddr=0, fb_wdata=0, frame_done=0, overrun=0, seg_rd_en=0.
  - busy=1 from the first cycle after reset.
- IDLE:
  - On frame_tick, snapshot length, head and food into registers, then go to CLEAR.
  - Live inputs are ignored for the rest of the frame.
- CLEAR:
  - Write CELL_EMPTY to addresses 0 .. GRID_W*GRID_H-1, one per cycle.
  - After the last address, go to SNAKE with seg counter=1.
  - If the snapshot length ≤ 1, go straight to HEAD.
- SNAKE:
  - seg_rd_en = !game_rd_req; seg_rd_addr = seg counter.
  - The counter advances only when a read is issued; game_rd_req stalls it indefinitely.
  - After issuing address length-1, go to DRAIN.
- Return write (any state): a pending flag is registered from seg_rd_en.
  - When pending && seg_valid_in && seg_x_in < GRID_W && seg_y_in < GRID_H, write CELL_SNAKE_BODY at seg_y_in*GRID_W + seg_x_in.
  - Otherwise fb_we=0 for that return.
- DRAIN: lasts one cycle so the last return can be written, then HEAD.
- HEAD: write CELL_SNAKE_HEAD at the head address if in bounds, then FOOD.
- FOOD:
  - Write CELL_FOOD at the food address if in bounds.
  - Pulse frame_done, then go to IDLE.
- Priority by write order: food overwrites head, head overwrites body.
- Address arithmetic: y*GRID_W + x, full width, truncated to FB_ADDR_W.
- frame_tick outside IDLE: ignored; overrun pulses in that same cycle.

## Timing
- A write decided in cycle N appears on fb_we / fb_waddr / fb_wdata in cycle N+1.
- Tick accepted in IDLE at cycle T: first clear write visible at T+2; last clear write visible at T+1+GRID_W*GRID_H.
- Unstalled SNAKE takes length-1 cycles, plus 1 DRAIN, 1 HEAD, 1 FOOD.
- frame_done is coincident with the registered food-write cycle.
- seg_rd_en falls in the same cycle that game_rd_req rises; there is no bubble and no lost request.
- A reset in any state aborts the frame. No further writes occur, and the block restarts at CLEAR address 0.

## Structure
- Shared package: cell codes CELL_EMPTY=00, CELL_SNAKE_BODY=01, CELL_SNAKE_HEAD=10, CELL_FOOD=11; FSM state encoding; the GRID_W*GRID_H depth constant.
- One sub-module, snake_seg_rd_arbiter: fixed-priority mux (game over controller) driving the shared RAM port and the grant.
- The FSM, the counters and the address multiply-add stay in this block.

## Test plan
- Reset release, then no tick → busy=1; 2400 writes of 00 to addresses 0..2399; then busy=0 and fb_we=0.
- Tick with length=3, segments (5,5),(6,5), head (7,5), food (10,20) → body writes at 305 and 306, head write 01=10 at 307, food write 11 at 1210 with frame_done high in that cycle.
- Same frame with game_rd_req high for 4 cycles mid-SNAKE → seg_rd_en=0 during the stall; writes are identical to the unstalled run but 4 cycles later.
- Segment (60,3) and food (0,40) → no write for either; head is still written; frame_done still pulses.
- Tick during CLEAR → overrun pulses once; the current frame completes unchanged; exactly one frame_done.
- sys_reset_n low for one cycle during SNAKE → the next visible write is address 0 with data 00; no body write from the in-flight read.
